// File: rtl/riscy_pkg.sv
// riscy_pkg: opcodes, sequencer states and writeback-source encodings shared by the RV32I control slice.
package riscy_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;
   localparam logic [1:0] WB_IMM = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd7
   } state_t;

   typedef struct packed {
      logic       is_load;
      logic       is_store;
      logic       is_branch;
      logic       is_jump;
      logic       writes_rd;
      logic       legal;
      logic       is_system;
      logic [1:0] wb_sel;
   } dec_t;

endpackage

// File: rtl/core_seq_if.sv
// core_seq_if: instruction/status inputs and datapath enables between the sequencer and the datapath.
interface core_seq_if #(parameter int CNT_W = 32);
   logic             run;
   logic [31:0]      inst;
   logic             branch_taken;
   logic             ir_en;
   logic             pc_inc_en;
   logic             pc_jump_en;
   logic             rf_w_en;
   logic             mem_w_en;
   logic [1:0]       mem_size;
   logic             mem_u_en;
   logic [1:0]       wb_sel;
   logic [2:0]       state;
   logic             halted;
   logic             trapped;
   logic             illegal;
   logic [CNT_W-1:0] instret;

   modport master (
      input  run, inst, branch_taken,
      output ir_en, pc_inc_en, pc_jump_en, rf_w_en, mem_w_en, mem_size, mem_u_en,
             wb_sel, state, halted, trapped, illegal, instret
   );

   modport slave (
      output run, inst, branch_taken,
      input  ir_en, pc_inc_en, pc_jump_en, rf_w_en, mem_w_en, mem_size, mem_u_en,
             wb_sel, state, halted, trapped, illegal, instret
   );
endinterface

// File: rtl/core_seq_op_decode.sv
// op_decode: classifies an RV32I instruction word into the control flags the sequencer needs.
module op_decode
   import riscy_pkg::*;
(
   input  logic [11:0] inst,
   output dec_t        dec
);
   logic [6:0] opc;
   assign opc = inst[6:0];
   always_comb begin
      dec           = '0;
      dec.is_load   = opc == OPC_LOAD;
      dec.is_store  = opc == OPC_STORE;
      dec.is_branch = opc == OPC_BRANCH;
      dec.is_jump   = opc == OPC_JAL || opc == OPC_JALR;
      dec.is_system = opc == OPC_SYSTEM;
      dec.legal     = opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                                  OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM};
      dec.writes_rd = (opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP,
                                   OPC_OP_IMM, OPC_LOAD}) && inst[11:7] != 5'd0;
      dec.wb_sel    = opc == OPC_LUI ? WB_IMM : dec.is_jump ? WB_PC4 : dec.is_load ? WB_MEM : WB_ALU;
   end
endmodule

// File: rtl/core_seq.sv
// core_seq: multi-cycle RV32I sequencer stepping fetch/decode/exec/mem/wb with retire counter and trap.
module core_seq
   import riscy_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic       clk,
   input  logic       reset,
   core_seq_if.master bus
);
   state_t           st, st_n;
   dec_t             dec;
   logic [CNT_W-1:0] cnt;
   logic             ill;
   logic             wb, take;

   op_decode u_dec (.inst(bus.inst[11:0]), .dec(dec));

   always_ff @(posedge clk) begin
      if (reset) begin
         st  <= S_IDLE;
         cnt <= '0;
         ill <= 1'b0;
      end else begin
         st <= st_n;
         if (st == S_WB) cnt <= cnt + CNT_W'(1);
         if (st == S_DECODE && !dec.legal && !dec.is_system) ill <= 1'b1;
      end
   end

   always_comb begin
      st_n = st;
      case (st)
         S_IDLE:   st_n = bus.run ? S_FETCH : S_IDLE;
         S_FETCH:  st_n = S_DECODE;
         S_DECODE: st_n = dec.legal ? S_EXEC : S_TRAP;
         S_EXEC:   st_n = (dec.is_load || dec.is_store) ? S_MEM : S_WB;
         S_MEM:    st_n = S_WB;
         S_WB:     st_n = bus.run ? S_FETCH : S_IDLE;
         default:  st_n = S_TRAP;
      endcase
   end

   // a taken branch or jump replaces the sequential pc step, so exactly one pc enable fires in WB
   assign wb   = st == S_WB;
   assign take = dec.is_jump || (dec.is_branch && bus.branch_taken);

   assign bus.ir_en      = st == S_FETCH;
   assign bus.pc_inc_en  = wb && !take;
   assign bus.pc_jump_en = wb && take;
   assign bus.rf_w_en    = wb && dec.writes_rd;
   assign bus.mem_w_en   = st == S_MEM && dec.is_store;
   assign bus.mem_size   = bus.inst[13:12];
   assign bus.mem_u_en   = bus.inst[14];
   assign bus.wb_sel     = wb ? dec.wb_sel : WB_ALU;
   assign bus.state      = st;
   assign bus.halted     = st == S_IDLE;
   assign bus.trapped    = st == S_TRAP;
   assign bus.illegal    = ill;
   assign bus.instret    = cnt;
endmodule
